// File: rtl/irq_pkg.sv
// Shared types, vector defaults and vector helper for the interrupt controller.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   localparam int unsigned VEC_BASE_DEF   = 32'h3C0;
   localparam int unsigned VEC_STRIDE_DEF = 8;
   localparam int unsigned SW_VECTOR_DEF  = 32'h3F8;

   // Caller truncates the result to its address width.
   function automatic int unsigned irq_vector(input int unsigned idx,
                                              input int unsigned base   = VEC_BASE_DEF,
                                              input int unsigned stride = VEC_STRIDE_DEF);
      return base + idx * stride;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line plus a one-cycle
// rising-edge pulse taken from the synchronised level.
module irq_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic line,
   output logic rise
);

   logic meta, sync, prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= line;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rise = sync & ~prev;

endmodule

// File: rtl/irq_controller.sv
// Fixed-priority, non-nesting interrupt controller feeding the CPU control unit.
// Optional periodic timer source enabled by defining IRQ_TIMER_EN.
//
// state   | meaning
// IDLE    | no handler active; arbitrates eligible pending bits
// REQUEST | s_interruption raised, grant and vector frozen until taken
// SERVICE | handler (hardware or SYSCALL) running until s_finish_interr
module irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned N_IRQ        = 4,
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned VEC_BASE     = VEC_BASE_DEF,
   parameter int unsigned VEC_STRIDE   = VEC_STRIDE_DEF,
   parameter int unsigned SW_VECTOR    = SW_VECTOR_DEF,
   parameter int unsigned TIMER_PERIOD = 1000,
`ifdef IRQ_TIMER_EN
   localparam int unsigned N_SRC = N_IRQ + 1
`else
   localparam int unsigned N_SRC = N_IRQ
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_IRQ-1:0]  irq_in,
   input  logic              we_mask,
   input  logic [N_SRC-1:0]  mask_data,
   input  logic              use_dir_interr,
   input  logic              s_finish_interr,
   output logic              s_interruption,
   output logic [ADDR_W-1:0] dir_interr,
   output logic              in_service,
   output logic [N_SRC-1:0]  irq_pending
);

   localparam int unsigned GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   irq_state_e        state_q, state_d;
   logic [GW-1:0]     grant_q, grant_d, win;
   logic [N_SRC-1:0]  pending_q, irq_mask, eligible, set_vec, clr_vec;
   logic [N_IRQ-1:0]  line_rise;
   logic              s_int_d, take;
   logic [ADDR_W-1:0] dir_d;

   for (genvar i = 0; i < int'(N_IRQ); i++) begin : g_sync
      irq_sync_edge u_sync (
         .clk   (clk),
         .reset (reset),
         .line  (irq_in[i]),
         .rise  (line_rise[i])
      );
   end

`ifdef IRQ_TIMER_EN
   localparam int unsigned TW = (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;
   logic [TW-1:0] timer_cnt;
   logic          timer_tick;

   // Down-counter 0 -> PERIOD-1 -> ... -> 1 ticks once per PERIOD cycles,
   // matching an up-counter that wraps from PERIOD-1 to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                timer_cnt <= '0;
      else if (timer_cnt == '0)  timer_cnt <= TW'(TIMER_PERIOD - 1);
      else                       timer_cnt <= timer_cnt - 1'b1;
   end

   assign timer_tick = (TIMER_PERIOD == 1) || (timer_cnt == TW'(1));
   assign set_vec    = {timer_tick, line_rise};
`else
   logic unused_timer;
   assign unused_timer = (TIMER_PERIOD == 0);
   assign set_vec      = line_rise;
`endif

   assign eligible = pending_q & irq_mask;

   always_comb begin
      win = '0;
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (eligible[i]) win = GW'(i);
      end
   end

   always_comb begin
      clr_vec = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         clr_vec[i] = take && (grant_q == GW'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      dir_d   = dir_interr;
      s_int_d = s_interruption;
      take    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|eligible) begin
               state_d = REQUEST;
               grant_d = win;
               dir_d   = ADDR_W'(irq_vector(32'(win), VEC_BASE, VEC_STRIDE));
               s_int_d = 1'b1;
            end else if (use_dir_interr) begin
               state_d = SERVICE;
               dir_d   = ADDR_W'(SW_VECTOR);
            end
         end
         REQUEST: begin
            if (use_dir_interr) begin
               state_d = SERVICE;
               s_int_d = 1'b0;
               take    = 1'b1;
            end
         end
         SERVICE: begin
            if (s_finish_interr) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            s_int_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         grant_q        <= '0;
         dir_interr     <= '0;
         s_interruption <= 1'b0;
         pending_q      <= '0;
         irq_mask       <= '1;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         dir_interr     <= dir_d;
         s_interruption <= s_int_d;
         // A new edge on the bit being cleared wins over the clear.
         pending_q      <= (pending_q & ~clr_vec) | set_vec;
         if (we_mask) irq_mask <= mask_data;
      end
   end

   assign in_service  = (state_q == SERVICE);
   assign irq_pending = pending_q;

endmodule
